// File: rtl/alu_operand_loader.sv
// alu_operand_loader: pushbutton/switch loader for ALU operands A, B and op code; define ALU_LOADER_DEBOUNCE_EN to build the key debouncer
package cpu_types_pkg;
  typedef logic [3:0] aluop_t;
endpackage

module alu_operand_loader
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  key_n,
  input  logic [16:0] sw,
  output logic [31:0] porta,
  output logic [31:0] portb,
  output aluop_t      aluop,
  output logic        valid,
  output logic [1:0]  state
);
  typedef enum logic [1:0] {LOAD_A = 2'd0, LOAD_B = 2'd1, LOAD_OP = 2'd2, DONE = 2'd3} state_t;
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'h0010_0000) begin : g_bad_cfg
    $error("DEBOUNCE_CYCLES out of range 2..2^20");
  end
  logic unused_keys;
  assign unused_keys = ^key_n[3:2];
  logic [1:0] meta_q, meta_d, sync_q, sync_d, prev_q, prev_d, press_q, press_d;
  logic [1:0] armed_q, armed_d, start_q, start_d, lvl;
  // Keys reset to released; presses are only armed once the key has been seen
  // released after reset, so a key held through reset never fires.
  always_comb begin
    meta_d  = key_n[1:0];
    sync_d  = meta_q;
    prev_d  = lvl;
    press_d = armed_q & prev_q & ~lvl;
    start_d = {start_q[0], 1'b1};
    armed_d = armed_q | ({2{start_q[1]}} & sync_q);
  end
  // Synchronizer, edge detector and post-reset arming flops
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      meta_q  <= '1;
      sync_q  <= '1;
      prev_q  <= '1;
      press_q <= '0;
      start_q <= '0;
      armed_q <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      press_q <= press_d;
      start_q <= start_d;
      armed_q <= armed_d;
    end
`ifdef ALU_LOADER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         lvl_q, lvl_d;
  // Count consecutive mismatches; the level flips on the DEBOUNCE_CYCLES-th one
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    for (int k = 0; k < 2; k++) begin
      cnt_d[k] = (sync_q[k] == lvl_q[k] || cnt_q[k] == LAST) ? '0 : cnt_q[k] + 1'b1;
      lvl_d[k] = (sync_q[k] != lvl_q[k] && cnt_q[k] == LAST) ? sync_q[k] : lvl_q[k];
    end
  end
  // Debounce counters and accepted key levels
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cnt_q <= '0;
      lvl_q <= '1;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  assign lvl = lvl_q;
`else
  assign lvl = sync_q;
`endif
  logic        ld, clr, valid_q, valid_d;
  logic [31:0] sw_ext, a_q, a_d, b_q, b_d;
  aluop_t      op_q, op_d;
  state_t      st_q, st_d;
  assign ld     = press_q[0];
  assign clr    = press_q[1];
  assign sw_ext = {{16{sw[16]}}, sw[15:0]};
  // Loader sequence; CLEAR overrides LOAD, DONE+LOAD restarts at operand A
  always_comb begin
    st_d    = st_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    valid_d = 1'b0;
    if (clr) begin
      st_d = LOAD_A;
      a_d  = '0;
      b_d  = '0;
      op_d = '0;
    end else if (ld) begin
      case (st_q)
        LOAD_A, DONE: begin a_d = sw_ext; st_d = LOAD_B; end
        LOAD_B:       begin b_d = sw_ext; st_d = LOAD_OP; end
        default:      begin op_d = sw[3:0]; st_d = DONE; valid_d = 1'b1; end
      endcase
    end
  end
  // FSM state and registered outputs
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      st_q    <= LOAD_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      valid_q <= valid_d;
    end
  assign porta = a_q;
  assign portb = b_q;
  assign aluop = op_q;
  assign valid = valid_q;
  assign state = st_q;
endmodule
